// File: rtl/dbg_sba_mem_bridge_pkg.sv
// Shared types and defaults for the debug-module SBA to core-complex memory bridge.
// The timeout feature is enabled by defining SBA_TIMEOUT_EN.
package dbg_sba_mem_bridge_pkg;

    localparam int unsigned SBA_ADDR_W      = 32;
    localparam int unsigned SBA_DATA_W      = 64;
    localparam logic [63:0] SBA_BASE_ADDR   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SBA_WIN_SIZE    = 64'h0000_0000_1000_0000;
    localparam int unsigned SBA_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        SBA_IDLE  = 3'd0,
        SBA_ISSUE = 3'd1,
        SBA_WAIT  = 3'd2,
        SBA_RESP  = 3'd3,
        SBA_DRAIN = 3'd4
    } sba_state_e;

    typedef struct packed {
        logic                    we;
        logic [SBA_ADDR_W-1:0]   addr;
        logic [SBA_DATA_W-1:0]   wdata;
        logic [SBA_DATA_W/8-1:0] be;
    } sba_mem_req_t;

endpackage

// File: rtl/dbg_sba_mem_bridge_timeout_cnt.sv
// Response timeout counter for the SBA bridge; instantiated only when SBA_TIMEOUT_EN is defined.
module sba_timeout_cnt
    import dbg_sba_mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = SBA_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires in the cycle where the count steps to TIMEOUT_CYC-1, so the
    // response slot lands exactly TIMEOUT_CYC cycles after the grant.
    assign expired_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_sba_mem_bridge.sv
// Bridges dm_top's req/gnt/r_valid SBA master port to a single-outstanding valid/ready memory channel.
// Define SBA_TIMEOUT_EN to add the response timeout counter and the DRAIN state.
module dbg_sba_mem_bridge
    import dbg_sba_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = SBA_ADDR_W,
    parameter int unsigned DATA_W      = SBA_DATA_W,
    parameter logic [63:0] BASE_ADDR   = SBA_BASE_ADDR,
    parameter logic [63:0] WIN_SIZE    = SBA_WIN_SIZE,
    parameter int unsigned TIMEOUT_CYC = SBA_TIMEOUT_CYC
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [63:0]         dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    output logic                dm_gnt_o,
    output logic                dm_r_valid_o,
    output logic [DATA_W-1:0]   dm_r_rdata_o,
    output logic                dm_r_err_o,
    output logic                dm_r_other_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_rdata_i,
    input  logic                mem_rsp_err_i
);

    // One extra bit so BASE_ADDR+WIN_SIZE at the top of the space cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(WIN_SIZE);

    sba_state_e          state_q, state_d;
    sba_mem_req_t        req_q, req_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                post_rst_q;
    logic                timeout_hit;
    logic [ADDR_W:0]     addr_ext;
    logic                addr_legal;
    logic                rsp_expected;

    assign addr_ext   = {1'b0, dm_addr_i[ADDR_W-1:0]};
    assign addr_legal = ((dm_addr_i >> ADDR_W) == 64'd0) && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

    assign dm_gnt_o        = rst_ni && (state_q == SBA_IDLE) && dm_req_i;
    assign dm_r_valid_o    = (state_q == SBA_RESP);
    assign dm_r_rdata_o    = rdata_q;
    assign dm_r_err_o      = err_q;
    assign mem_req_valid_o = (state_q == SBA_ISSUE);
    assign mem_we_o        = req_q.we;
    assign mem_addr_o      = ADDR_W'(req_q.addr);
    assign mem_wdata_o     = req_q.wdata;
    assign mem_be_o        = req_q.be;

`ifdef SBA_TIMEOUT_EN
    logic oerr_q, oerr_d;
    logic drain_q, drain_d;

    sba_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (dm_gnt_o),
        .en_i      ((state_q == SBA_ISSUE) || (state_q == SBA_WAIT)),
        .expired_o (timeout_hit)
    );

    assign dm_r_other_err_o = oerr_q;
    assign rsp_expected = (state_q == SBA_WAIT) || (state_q == SBA_DRAIN)
                       || ((state_q == SBA_ISSUE) && mem_req_ready_i);
`else
    assign timeout_hit      = 1'b0;
    assign dm_r_other_err_o = 1'b0;
    assign rsp_expected = (state_q == SBA_WAIT) || ((state_q == SBA_ISSUE) && mem_req_ready_i);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef SBA_TIMEOUT_EN
        oerr_d  = oerr_q;
        drain_d = drain_q;
`endif
        case (state_q)
            SBA_IDLE: begin
                if (dm_gnt_o) begin
                    req_d.we    = dm_we_i;
                    req_d.addr  = SBA_ADDR_W'(dm_addr_i[ADDR_W-1:0]);
                    req_d.wdata = dm_wdata_i;
                    req_d.be    = dm_be_i;
                    if (addr_legal) begin
                        state_d = SBA_ISSUE;
                    end else begin
                        state_d = SBA_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
`ifdef SBA_TIMEOUT_EN
                        oerr_d  = 1'b0;
                        drain_d = 1'b0;
`endif
                    end
                end
            end
            SBA_ISSUE: begin
                if (mem_req_ready_i && mem_rsp_valid_i) begin
                    state_d = SBA_RESP;
                    rdata_d = req_q.we ? '0 : mem_rsp_rdata_i;
                    err_d   = mem_rsp_err_i;
`ifdef SBA_TIMEOUT_EN
                    oerr_d  = 1'b0;
                    drain_d = 1'b0;
                end else if (timeout_hit) begin
                    // If the slave took the request this cycle its response is still owed.
                    state_d = SBA_RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    oerr_d  = 1'b1;
                    drain_d = mem_req_ready_i;
`endif
                end else if (mem_req_ready_i) begin
                    state_d = SBA_WAIT;
                end
            end
            SBA_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = SBA_RESP;
                    rdata_d = req_q.we ? '0 : mem_rsp_rdata_i;
                    err_d   = mem_rsp_err_i;
`ifdef SBA_TIMEOUT_EN
                    oerr_d  = 1'b0;
                    drain_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d = SBA_RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    oerr_d  = 1'b1;
                    drain_d = 1'b1;
`endif
                end
            end
            SBA_RESP: begin
                state_d = SBA_IDLE;
`ifdef SBA_TIMEOUT_EN
                if (drain_q) begin
                    state_d = SBA_DRAIN;
                end
            end
            SBA_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    state_d = SBA_IDLE;
                end
`endif
            end
            default: state_d = SBA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SBA_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            post_rst_q <= 1'b1;
`ifdef SBA_TIMEOUT_EN
            oerr_q     <= 1'b0;
            drain_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            post_rst_q <= 1'b0;
`ifdef SBA_TIMEOUT_EN
            oerr_q     <= oerr_d;
            drain_q    <= drain_d;
`endif
        end
    end

    // Stray responses are dropped; the first cycle after reset may still carry an abandoned one.
    a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_rsp_valid_i && !post_rst_q) |-> rsp_expected);

    a_timeout_cfg: assert property (@(posedge clk_i) TIMEOUT_CYC >= 2);

endmodule
